// File: rtl/snow2_pkg.sv
// Shared types and default sizes for the SNOW 2.0 keystream sequencer.
package snow2_pkg;

    localparam int unsigned KEY_W           = 128;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned INIT_ROUNDS_DEF = 32;
    localparam int unsigned DISCARD_DEF     = 1;
    localparam int unsigned LEN_W_DEF       = 16;
    localparam int unsigned RND_W           = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StInit,
        StDisc,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/snow2_ks_buf.sv
// One-entry valid/ready output register for keystream words.
module snow2_ks_buf
    import snow2_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    input  logic              ready,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              fire,
    output logic              space
);

    logic [WORD_W-1:0] data_q;
    logic              valid_q;

    assign data  = data_q;
    assign valid = valid_q;
    assign fire  = valid_q && ready;
    // Space exists when empty or when the held word leaves at this edge.
    assign space = !valid_q || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= din;
            valid_q <= 1'b1;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/snow2_ctrl.sv
// SNOW 2.0 sequencer: key/IV load, init rounds, warm-up discard, then a
// backpressured keystream stream that steps the core once per delivered word.
module snow2_ctrl
    import snow2_pkg::*;
#(
    parameter int unsigned INIT_ROUNDS = INIT_ROUNDS_DEF,
    parameter int unsigned DISCARD     = DISCARD_DEF,
    parameter int unsigned LEN_W       = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KEY_W-1:0]  s_key,
    input  logic [KEY_W-1:0]  iv,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_valid,
    input  logic              ks_ready,
    output logic [KEY_W-1:0]  core_key,
    output logic [KEY_W-1:0]  core_iv,
    output logic              core_load,
    output logic              core_init,
    output logic              core_step,
    input  logic [WORD_W-1:0] core_ks
);

    localparam logic [RND_W-1:0] INIT_LAST = RND_W'(INIT_ROUNDS - 1);
    localparam logic [RND_W-1:0] DISC_LAST = RND_W'(DISCARD - 1);

    state_e           state_q;
    logic [RND_W-1:0] rnd_q;
    logic [LEN_W-1:0] num_q;
    logic [LEN_W-1:0] sent_q;
    logic [LEN_W-1:0] sent_nxt;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] iv_q;
    logic             busy_q;
    logic             done_q;
    logic             load_q;
    logic             init_q;
    logic             step_q;
    logic             run_adv;
    logic             buf_fire;
    logic             buf_space;

    // RUN steps the core combinationally so a ready consumer sees no bubbles.
    assign run_adv  = (state_q == StRun) && buf_space && !abort;
    assign sent_nxt = sent_q + LEN_W'(1);

    assign busy      = busy_q;
    assign done      = done_q;
    assign core_key  = key_q;
    assign core_iv   = iv_q;
    assign core_load = load_q;
    assign core_init = init_q;
    assign core_step = step_q || run_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rnd_q   <= '0;
            num_q   <= '0;
            sent_q  <= '0;
            key_q   <= '0;
            iv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            init_q  <= 1'b0;
            step_q  <= 1'b0;
        end else if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            init_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q   <= s_key;
                        iv_q    <= iv;
                        num_q   <= num_words;
                        sent_q  <= '0;
                        busy_q  <= 1'b1;
                        load_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    load_q  <= 1'b0;
                    init_q  <= 1'b1;
                    step_q  <= 1'b1;
                    rnd_q   <= '0;
                    state_q <= StInit;
                end
                StInit: begin
                    if (rnd_q == INIT_LAST) begin
                        init_q <= 1'b0;
                        rnd_q  <= '0;
                        if (DISCARD == 0) begin
                            step_q  <= 1'b0;
                            state_q <= StRun;
                        end else begin
                            state_q <= StDisc;
                        end
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                StDisc: begin
                    if (rnd_q == DISC_LAST) begin
                        step_q  <= 1'b0;
                        state_q <= StRun;
                    end else begin
                        rnd_q <= rnd_q + RND_W'(1);
                    end
                end
                StRun: begin
                    if (run_adv) begin
                        sent_q <= sent_nxt;
                        // num_words of 0 never terminates; the count wraps freely.
                        if (num_q != '0 && sent_nxt == num_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (buf_fire) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    snow2_ks_buf u_ks_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .load  (run_adv),
        .din   (core_ks),
        .ready (ks_ready),
        .data  (ks_data),
        .valid (ks_valid),
        .fire  (buf_fire),
        .space (buf_space)
    );

endmodule
